// File: rtl/absdiff_pkg.sv
// -----------------------------------------------------------------------------
// absdiff_pkg
// Shared definitions for the absolute-difference accumulator slice:
//   - state_e     : 2-bit FSM state encoding used by absdiff_ctrl
//   - DEF_WIDTH   : default operand / magnitude width
//   - DEF_ACC_W   : default accumulator width
// -----------------------------------------------------------------------------
package absdiff_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_ACC_W = DEF_WIDTH + 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_SUB  = 2'b01,
        S_CONV = 2'b10,
        S_DONE = 2'b11
    } state_e;

endpackage : absdiff_pkg

// File: rtl/absdiff_if.sv
// -----------------------------------------------------------------------------
// absdiff_if
// Request / result bundle of absdiff_acc.
//   master : drives start_i, a_i, b_i, mode_i, clr_acc_i; observes results
//   slave  : the accumulator block; drives busy_o, done_o, diff_o, a_lt_b_o,
//            acc_o, acc_ovf_o
// -----------------------------------------------------------------------------
interface absdiff_if #(
    parameter int WIDTH = absdiff_pkg::DEF_WIDTH,
    parameter int ACC_W = absdiff_pkg::DEF_ACC_W
);
    logic             start_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             mode_i;
    logic             clr_acc_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] diff_o;
    logic             a_lt_b_o;
    logic [ACC_W-1:0] acc_o;
    logic             acc_ovf_o;

    modport master (
        output start_i, a_i, b_i, mode_i, clr_acc_i,
        input  busy_o, done_o, diff_o, a_lt_b_o, acc_o, acc_ovf_o
    );

    modport slave (
        input  start_i, a_i, b_i, mode_i, clr_acc_i,
        output busy_o, done_o, diff_o, a_lt_b_o, acc_o, acc_ovf_o
    );
endinterface : absdiff_if

// File: rtl/absdiff_ctrl.sv
// -----------------------------------------------------------------------------
// absdiff_ctrl
// Sequencing FSM for absdiff_acc: IDLE -> SUB -> (CONV when A<B) -> DONE.
// Ports:
//   clk_i, rst_b_i : clock, asynchronous active-low reset
//   start_i        : operation request, only looked at in S_IDLE
//   carry_i        : carry-out of A + ~B + 1 during S_SUB (1 means A >= B)
//   load_o         : capture operands and mode this cycle
//   sub_o          : datapath performs the subtraction this cycle
//   conv_o         : datapath negates the result this cycle
//   done_o         : result complete (one-cycle pulse)
//   busy_o         : any state other than S_IDLE
// -----------------------------------------------------------------------------
module absdiff_ctrl
    import absdiff_pkg::*;
(
    input  logic clk_i,
    input  logic rst_b_i,
    input  logic start_i,
    input  logic carry_i,
    output logic load_o,
    output logic sub_o,
    output logic conv_o,
    output logic done_o,
    output logic busy_o
);

    state_e state_q, state_d;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    always_ff @(posedge clk_i or negedge rst_b_i) begin
        if (!rst_b_i) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        load_o  = 1'b0;
        sub_o   = 1'b0;
        conv_o  = 1'b0;
        done_o  = 1'b0;
        busy_o  = 1'b1;
        unique case (state_q)
            S_IDLE: begin
                busy_o = 1'b0;
                if (start_i) begin
                    load_o  = 1'b1;
                    state_d = S_SUB;
                end
            end
            S_SUB: begin
                sub_o   = 1'b1;
                state_d = carry_i ? S_DONE : S_CONV;
            end
            S_CONV: begin
                conv_o  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                // start_i is ignored here; a new request is taken in S_IDLE.
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule : absdiff_ctrl

// File: rtl/absdiff_acc.sv
// -----------------------------------------------------------------------------
// absdiff_acc
// Multi-cycle |A-B| unit with an optional running sum of the magnitudes.
// Ports:
//   clk_i, rst_b_i : clock, asynchronous active-low reset
//   bus            : absdiff_if slave - start_i/a_i/b_i/mode_i/clr_acc_i in,
//                    busy_o/done_o/diff_o/a_lt_b_o/acc_o/acc_ovf_o out
// Latency from the start cycle: done_o in cycle 2 (A>=B) or 3 (A<B);
// diff_o / a_lt_b_o / acc_o update on the edge that ends the done_o cycle.
// -----------------------------------------------------------------------------
module absdiff_acc
    import absdiff_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic      clk_i,
    input  logic      rst_b_i,
    absdiff_if.slave  bus
);

    logic             load, sub, conv, done, busy;
    logic [WIDTH-1:0] a_q, b_q, r_q, diff_q;
    logic             mode_q, lt_q, a_lt_b_q;
    logic [ACC_W-1:0] acc_q;
    logic             ovf_q;
    logic [WIDTH:0]   sub_sum;
    logic [ACC_W:0]   acc_sum;

    // A + ~B + 1 at WIDTH+1 bits: the top bit is the "no borrow" carry (A >= B).
    assign sub_sum = {1'b0, a_q} + {1'b0, ~b_q} + (WIDTH + 1)'(1);
    // Extra top bit carries the accumulator wrap out.
    assign acc_sum = {1'b0, acc_q} + (ACC_W + 1)'(r_q);

    absdiff_ctrl u_ctrl (
        .clk_i   (clk_i),
        .rst_b_i (rst_b_i),
        .start_i (bus.start_i),
        .carry_i (sub_sum[WIDTH]),
        .load_o  (load),
        .sub_o   (sub),
        .conv_o  (conv),
        .done_o  (done),
        .busy_o  (busy)
    );

    // NOTE: all datapath registers are reset, not just the control state, so
    // an abort mid-operation leaves no stale operand or result visible.
    always_ff @(posedge clk_i or negedge rst_b_i) begin
        if (!rst_b_i) begin
            a_q      <= '0;
            b_q      <= '0;
            mode_q   <= 1'b0;
            r_q      <= '0;
            lt_q     <= 1'b0;
            diff_q   <= '0;
            a_lt_b_q <= 1'b0;
        end else begin
            if (load) begin
                a_q    <= bus.a_i;
                b_q    <= bus.b_i;
                mode_q <= bus.mode_i;
                lt_q   <= 1'b0;
            end
            if (sub) r_q <= sub_sum[WIDTH-1:0];
            if (conv) begin
                // Borrow case: the subtraction left B-A in two's complement.
                r_q  <= ~r_q + WIDTH'(1);
                lt_q <= 1'b1;
            end
            if (done) begin
                diff_q   <= r_q;
                a_lt_b_q <= lt_q;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_b_i) begin
        if (!rst_b_i) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else if (bus.clr_acc_i) begin
            // Clear takes priority over a coinciding accumulate.
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else if (done && mode_q) begin
            acc_q <= acc_sum[ACC_W-1:0];
            if (acc_sum[ACC_W]) ovf_q <= 1'b1;
        end
    end

    assign bus.busy_o    = busy;
    assign bus.done_o    = done;
    assign bus.diff_o    = diff_q;
    assign bus.a_lt_b_o  = a_lt_b_q;
    assign bus.acc_o     = acc_q;
    assign bus.acc_ovf_o = ovf_q;

endmodule : absdiff_acc

// File: tb/tb_absdiff_acc.sv
// -----------------------------------------------------------------------------
// tb_absdiff_acc
// Two instances share one stimulus stream: WIDTH=8/ACC_W=16 and WIDTH=8/ACC_W=9.
// A plain-arithmetic model tracks |A-B|, A<B and both accumulators.
// -----------------------------------------------------------------------------
module tb_absdiff_acc;

    logic       clk;
    logic       rst_b;
    logic       start, mode, clr_acc;
    logic [7:0] a_in, b_in;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int exp_diff = 0;
    int exp_lt   = 0;
    int acc16_m  = 0;
    int ovf16_m  = 0;
    int acc9_m   = 0;
    int ovf9_m   = 0;

    absdiff_if #(.WIDTH(8), .ACC_W(16)) if16 ();
    absdiff_if #(.WIDTH(8), .ACC_W(9))  if9 ();

    assign if16.start_i   = start;
    assign if16.a_i       = a_in;
    assign if16.b_i       = b_in;
    assign if16.mode_i    = mode;
    assign if16.clr_acc_i = clr_acc;
    assign if9.start_i    = start;
    assign if9.a_i        = a_in;
    assign if9.b_i        = b_in;
    assign if9.mode_i     = mode;
    assign if9.clr_acc_i  = clr_acc;

    absdiff_acc #(.WIDTH(8), .ACC_W(16)) dut16 (
        .clk_i   (clk),
        .rst_b_i (rst_b),
        .bus     (if16)
    );

    absdiff_acc #(.WIDTH(8), .ACC_W(9)) dut9 (
        .clk_i   (clk),
        .rst_b_i (rst_b),
        .bus     (if9)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_add(input int mag);
        acc16_m = acc16_m + mag;
        if (acc16_m >= 65536) begin acc16_m -= 65536; ovf16_m = 1; end
        acc9_m = acc9_m + mag;
        if (acc9_m >= 512) begin acc9_m -= 512; ovf9_m = 1; end
    endtask

    task automatic check_outputs(input string tag);
        checks++; if (if16.diff_o !== 8'(exp_diff)) begin errors++;
            $display("FAIL %s diff16: got %0d want %0d", tag, if16.diff_o, exp_diff); end
        checks++; if (if16.a_lt_b_o !== 1'(exp_lt)) begin errors++;
            $display("FAIL %s lt16: got %0d want %0d", tag, if16.a_lt_b_o, exp_lt); end
        checks++; if (if16.acc_o !== 16'(acc16_m)) begin errors++;
            $display("FAIL %s acc16: got %0d want %0d", tag, if16.acc_o, acc16_m); end
        checks++; if (if16.acc_ovf_o !== 1'(ovf16_m)) begin errors++;
            $display("FAIL %s ovf16: got %0d want %0d", tag, if16.acc_ovf_o, ovf16_m); end
        checks++; if (if9.diff_o !== 8'(exp_diff)) begin errors++;
            $display("FAIL %s diff9: got %0d want %0d", tag, if9.diff_o, exp_diff); end
        checks++; if (if9.acc_o !== 9'(acc9_m)) begin errors++;
            $display("FAIL %s acc9: got %0d want %0d", tag, if9.acc_o, acc9_m); end
        checks++; if (if9.acc_ovf_o !== 1'(ovf9_m)) begin errors++;
            $display("FAIL %s ovf9: got %0d want %0d", tag, if9.acc_ovf_o, ovf9_m); end
    endtask

    // One operation from S_IDLE, optionally pulsing clr_acc_i in the done cycle.
    task automatic run_op(input int a, input int b, input int md, input bit clr_at_done,
                          input string tag);
        int cycles;
        int lat;
        start = 1'b1; a_in = 8'(a); b_in = 8'(b); mode = 1'(md);
        tick();
        cycles = 1;
        start = 1'b0;
        a_in = 8'($urandom); b_in = 8'($urandom); mode = 1'($urandom);
        while (!if16.done_o && cycles < 8) begin
            tick();
            cycles++;
        end
        lat = (a < b) ? 3 : 2;
        checks++; if (cycles !== lat) begin errors++;
            $display("FAIL %s latency: got %0d want %0d", tag, cycles, lat); end
        checks++; if (if9.done_o !== 1'b1 || if16.busy_o !== 1'b1) begin errors++;
            $display("FAIL %s done9/busy: got %0d/%0d want 1/1", tag, if9.done_o, if16.busy_o); end
        // Registered result must not change until after the done cycle.
        checks++; if (if16.diff_o !== 8'(exp_diff)) begin errors++;
            $display("FAIL %s early_diff: got %0d want %0d", tag, if16.diff_o, exp_diff); end
        if (clr_at_done) clr_acc = 1'b1;
        tick();
        clr_acc = 1'b0;
        exp_diff = (a >= b) ? a - b : b - a;
        exp_lt   = (a < b) ? 1 : 0;
        if (clr_at_done) begin
            acc16_m = 0; ovf16_m = 0; acc9_m = 0; ovf9_m = 0;
        end else if (md != 0) begin
            model_add(exp_diff);
        end
        checks++; if (if16.done_o !== 1'b0 || if16.busy_o !== 1'b0) begin errors++;
            $display("FAIL %s idle: got done=%0d busy=%0d want 0/0", tag, if16.done_o, if16.busy_o); end
        check_outputs(tag);
    endtask

    task automatic test_reset();
        checks++; if ({if16.busy_o, if16.done_o, if16.diff_o, if16.a_lt_b_o, if16.acc_o, if16.acc_ovf_o} !== '0) begin
            errors++; $display("FAIL reset_state: got busy=%0d acc=%0d want all 0", if16.busy_o, if16.acc_o); end
        rst_b = 1'b1;
        run_op(30, 77, 1, 1'b0, "pre_reset");
        start = 1'b1; a_in = 8'd9; b_in = 8'd4; mode = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (if16.busy_o !== 1'b1) begin errors++;
            $display("FAIL in_sub busy: got %0d want 1", if16.busy_o); end
        rst_b = 1'b0;
        #1;
        exp_diff = 0; exp_lt = 0; acc16_m = 0; ovf16_m = 0; acc9_m = 0; ovf9_m = 0;
        checks++; if (if16.busy_o !== 1'b0 || if16.done_o !== 1'b0) begin errors++;
            $display("FAIL mid_reset busy/done: got %0d/%0d want 0/0", if16.busy_o, if16.done_o); end
        check_outputs("mid_reset");
        #2;
        rst_b = 1'b1;
        tick();
        run_op(9, 4, 1, 1'b0, "after_reset");
    endtask

    task automatic test_magnitude();
        int acc_before;
        acc_before = acc16_m;
        run_op(200, 55, 0, 1'b0, "a_ge_b");
        checks++; if (if16.diff_o !== 8'd145 || if16.acc_o !== 16'(acc_before)) begin errors++;
            $display("FAIL a_ge_b const: got diff=%0d acc=%0d want 145 %0d", if16.diff_o, if16.acc_o, acc_before); end
        run_op(55, 200, 0, 1'b0, "a_lt_b");
        checks++; if (if16.diff_o !== 8'd145 || if16.a_lt_b_o !== 1'b1) begin errors++;
            $display("FAIL a_lt_b const: got diff=%0d lt=%0d want 145 1", if16.diff_o, if16.a_lt_b_o); end
        run_op(8'h80, 8'h80, 0, 1'b0, "equal");
        run_op(0, 255, 0, 1'b0, "extreme");
        run_op(255, 0, 0, 1'b0, "extreme_rev");
    endtask

    task automatic test_accumulate();
        clr_acc = 1'b1;
        tick();
        clr_acc = 1'b0;
        acc16_m = 0; ovf16_m = 0; acc9_m = 0; ovf9_m = 0;
        check_outputs("clr");
        run_op(10, 3, 1, 1'b0, "acc_7");
        run_op(3, 10, 1, 1'b0, "acc_14");
        run_op(255, 0, 1, 1'b0, "acc_269");
        checks++; if (if16.acc_o !== 16'd269 || if16.acc_ovf_o !== 1'b0) begin errors++;
            $display("FAIL acc_269 const: got %0d ovf=%0d want 269 0", if16.acc_o, if16.acc_ovf_o); end
    endtask

    task automatic test_acc_wrap();
        clr_acc = 1'b1;
        tick();
        clr_acc = 1'b0;
        acc16_m = 0; ovf16_m = 0; acc9_m = 0; ovf9_m = 0;
        run_op(255, 0, 1, 1'b0, "w9_255");
        run_op(255, 0, 1, 1'b0, "w9_510");
        checks++; if (if9.acc_o !== 9'd510 || if9.acc_ovf_o !== 1'b0) begin errors++;
            $display("FAIL w9_510 const: got %0d ovf=%0d want 510 0", if9.acc_o, if9.acc_ovf_o); end
        run_op(255, 0, 1, 1'b0, "w9_253");
        checks++; if (if9.acc_o !== 9'd253 || if9.acc_ovf_o !== 1'b1) begin errors++;
            $display("FAIL w9_253 const: got %0d ovf=%0d want 253 1", if9.acc_o, if9.acc_ovf_o); end
        run_op(1, 1, 1, 1'b0, "w9_sticky");
        clr_acc = 1'b1;
        tick();
        clr_acc = 1'b0;
        acc16_m = 0; ovf16_m = 0; acc9_m = 0; ovf9_m = 0;
        check_outputs("w9_clr");
    endtask

    task automatic test_back_to_back();
        int dones;
        int idles;
        dones = 0; idles = 0;
        start = 1'b1; a_in = 8'd55; b_in = 8'd200; mode = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (if16.done_o) dones++;
            if (!if16.busy_o) idles++;
            if (i < 19) tick();
        end
        start = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) model_add(145);
        exp_diff = 145; exp_lt = 1;
        checks++; if (dones !== 5 || idles !== 5) begin errors++;
            $display("FAIL held_start: got dones=%0d idles=%0d want 5 5", dones, idles); end
        check_outputs("held_start");
        run_op(40, 12, 1, 1'b1, "clr_at_done");
        checks++; if (if16.acc_o !== 16'd0 || if9.acc_o !== 9'd0) begin errors++;
            $display("FAIL clr_at_done const: got %0d/%0d want 0/0", if16.acc_o, if9.acc_o); end
    endtask

    task automatic test_random();
        int a, b, md;
        for (int n = 0; n < 24; n++) begin
            a  = int'($urandom_range(0, 255));
            b  = (n % 6 == 5) ? a : int'($urandom_range(0, 255));
            md = int'($urandom_range(0, 1));
            run_op(a, b, md, 1'b0, "random");
        end
    endtask

    initial begin
        rst_b = 1'b0; start = 1'b0; mode = 1'b0; clr_acc = 1'b0;
        a_in = '0; b_in = '0;
        tick();
        tick();
        test_reset();
        test_magnitude();
        test_accumulate();
        test_acc_wrap();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_absdiff_acc

// File: doc/absdiff_acc.md
ABSDIFF_ACC -- requirements
Module: absdiff_acc

Interface
REQ-001 Parameter WIDTH, default 8, operand and magnitude width (>= 2).
REQ-002 Parameter ACC_W, default WIDTH+8, accumulator width (>= WIDTH+1).
REQ-003 clk_i  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_b_i  input  1  reset, asynchronous, active-low.
REQ-005 start_i  input  1  request one operation; sampled only in S_IDLE.
REQ-006 a_i  input  WIDTH  unsigned operand A; captured in the start cycle.
REQ-007 b_i  input  WIDTH  unsigned operand B; captured in the start cycle.
REQ-008 mode_i  input  1  0 = magnitude only, 1 = also add the magnitude to the accumulator; captured in the start cycle.
REQ-009 clr_acc_i  input  1  synchronous clear of the accumulator and the overflow flag; honoured in any state.
REQ-010 busy_o  output  1  high in every state except S_IDLE.
REQ-011 done_o  output  1  one-cycle pulse in S_DONE.
REQ-012 diff_o  output  WIDTH  |A-B|; valid from done_o, held until the next S_DONE.
REQ-013 a_lt_b_o  output  1  A < B for the last result; held with diff_o.
REQ-014 acc_o  output  ACC_W  running sum of magnitudes.
REQ-015 acc_ovf_o  output  1  sticky accumulator wrap flag.

Function
REQ-016 The FSM SHALL have the states S_IDLE, S_SUB, S_CONV and S_DONE.
REQ-017 S_IDLE with start_i=1: load A and B and the mode into internal registers; next state S_SUB. Otherwise stay in S_IDLE.
REQ-018 S_SUB: R <= A + ~B + 1 computed at WIDTH+1 bits, with the carry-out captured. Carry=1 (A>=B) goes to S_DONE; carry=0 goes to S_CONV.
REQ-019 S_CONV: R <= ~R + 1 (two's-complement negation, truncated to WIDTH); a_lt_b register <= 1; next state S_DONE.
REQ-020 S_DONE: done_o=1. At the clock edge, diff_o <= R and a_lt_b_o <= latched flag (0 if no S_CONV); next state S_IDLE. Registered outputs SHALL show the new value in the cycle after done_o; the internal R is valid during done_o.
REQ-021 Latency from the start_i cycle (cycle 0): done_o in cycle 2 when A>=B, cycle 3 when A<B.
REQ-022 start_i while busy_o=1, including in S_DONE, SHALL be ignored. A new start is accepted in the first S_IDLE cycle.
REQ-023 Latched mode=1 in S_DONE: acc <= acc + zero-extend(R) modulo 2^ACC_W. acc_ovf_o <= 1 if the carry out of ACC_W is set; once set it stays set.
REQ-024 clr_acc_i=1: acc <= 0 and acc_ovf_o <= 0 at the next edge. When it coincides with the S_DONE accumulate, the clear wins and that magnitude is discarded.
REQ-025 A==B SHALL give diff 0 and a_lt_b 0 with 2-cycle latency. A=0, B=2^WIDTH-1 SHALL give diff 2^WIDTH-1 and a_lt_b 1.
REQ-026 Operand changes after the start cycle SHALL NOT affect the result.

Reset
REQ-027 rst_b_i low SHALL immediately force S_IDLE and clear busy_o, done_o, diff_o, a_lt_b_o, acc_o, acc_ovf_o and all internal registers to 0, including mid-operation.
REQ-028 After reset release, the first rising edge with start_i=1 SHALL begin an operation normally.

Structure
REQ-029 Shared package absdiff_pkg SHALL hold the 2-bit state encodings (S_IDLE=00, S_SUB=01, S_CONV=10, S_DONE=11) and the default WIDTH/ACC_W constants.
REQ-030 The FSM (next-state and control decode) SHALL be sub-module absdiff_ctrl. It takes start_i and carry as inputs and drives load, sub, conv and done controls. The datapath registers stay in absdiff_acc.

Verification (WIDTH=8, ACC_W=16 unless noted)
REQ-031 Reset: assert rst_b_i mid-S_SUB -> all outputs 0 and busy_o 0 in the same cycle; a fresh start after release completes normally.
REQ-032 A=200, B=55, mode 0 -> done_o in cycle 2, diff_o=145, a_lt_b_o=0, acc_o unchanged.
REQ-033 A=55, B=200 -> done_o in cycle 3, diff_o=145, a_lt_b_o=1. Also A=B=0x80 -> diff_o=0 in cycle 2.
REQ-034 clr_acc_i, then mode 1 pairs (10,3), (3,10), (255,0) -> acc_o = 7, 14, 269, with acc_ovf_o=0 throughout.
REQ-035 ACC_W=9 instance: (255,0) three times with mode 1 -> acc_o = 255, 510, 253, with acc_ovf_o=1 after the third. A following clr_acc_i -> 0 and 0.
REQ-036 start_i held high continuously -> exactly one operation per S_IDLE visit. clr_acc_i in the S_DONE cycle of a mode 1 op -> acc_o=0.
